// File: rtl/bird_slot_scheduler_if.sv
// rtl/bird_slot_scheduler_if.sv - frame/hit inputs and spawn/status outputs of the bird slot scheduler
interface bird_slot_scheduler_if;
    logic       startOfFrame;
    logic       enable;
    logic       bird1Hit;
    logic       bird2Hit;
    logic       bird1Exited;
    logic       bird2Exited;
    logic       bird1Spawn;
    logic       bird2Spawn;
    logic       bird1Active;
    logic       bird2Active;
    logic       spawnSide;
    logic [7:0] spawnY;
    logic [7:0] hitCount;

    modport slave (
        input  startOfFrame, enable, bird1Hit, bird2Hit, bird1Exited, bird2Exited,
        output bird1Spawn, bird2Spawn, bird1Active, bird2Active, spawnSide, spawnY, hitCount
    );

    modport master (
        output startOfFrame, enable, bird1Hit, bird2Hit, bird1Exited, bird2Exited,
        input  bird1Spawn, bird2Spawn, bird1Active, bird2Active, spawnSide, spawnY, hitCount
    );
endinterface

// File: rtl/bird_slot_scheduler.sv
// rtl/bird_slot_scheduler.sv - two-slot bird spawn scheduler with cooldown, LFSR spawn position and hit counter
module bird_slot_scheduler #(
    parameter int         SPAWN_PERIOD  = 120,
    parameter int         RESPAWN_DELAY = 60,
    parameter logic [7:0] LFSR_SEED     = 8'hA5
) (
    input  logic                  clk,
    input  logic                  resetN,
    bird_slot_scheduler_if.slave  bus
);

    typedef enum logic [1:0] {
        ST_FREE     = 2'd0,
        ST_ACTIVE   = 2'd1,
        ST_COOLDOWN = 2'd2
    } slot_state_t;

    localparam logic [7:0] LP_LAST  = 8'(SPAWN_PERIOD - 1);
    localparam logic [7:0] LP_DELAY = 8'(RESPAWN_DELAY);

    slot_state_t r_state [2];
    logic [7:0]  r_cool  [2];
    logic [7:0]  r_timer;
    logic [7:0]  r_lfsr;
    logic [7:0]  r_spawn_y;
    logic [7:0]  r_hit_count;
    logic        r_pending;
    logic        r_spawn_side;
    logic [1:0]  r_spawn;
    logic [1:0]  r_active;

    logic        w_tick;
    logic        w_spawn;
    logic        w_timer_done;
    logic        w_lfsr_fb;
    logic [1:0]  w_hit;
    logic [1:0]  w_leave;
    logic [1:0]  w_free;
    logic [1:0]  w_sel;
    logic [1:0]  w_hit_inc;
    logic [8:0]  w_hit_sum;

    assign w_tick       = bus.startOfFrame & bus.enable;
    assign w_timer_done = w_tick && (r_timer == LP_LAST);
    assign w_lfsr_fb    = r_lfsr[7] ^ r_lfsr[5] ^ r_lfsr[4] ^ r_lfsr[3];

    assign w_hit   = {bus.bird2Hit, bus.bird1Hit};
    assign w_leave = {bus.bird2Hit | bus.bird2Exited, bus.bird1Hit | bus.bird1Exited};
    assign w_free  = {r_state[1] == ST_FREE, r_state[0] == ST_FREE};

    // Bird1 has priority; a single pending request can start at most one slot.
    assign w_spawn = r_pending & bus.enable & (|w_free);
    assign w_sel   = {w_spawn & ~w_free[0] & w_free[1], w_spawn & w_free[0]};

    // A hit and an exit together on one slot count once, so only the hit inputs feed the counter.
    assign w_hit_inc = {1'b0, (r_state[0] == ST_ACTIVE) & w_hit[0]}
                     + {1'b0, (r_state[1] == ST_ACTIVE) & w_hit[1]};
    assign w_hit_sum = {1'b0, r_hit_count} + {7'd0, w_hit_inc};

    always_ff @(posedge clk) begin
        if (resetN) begin
            r_timer      <= '0;
            r_lfsr       <= LFSR_SEED;
            r_spawn_y    <= '0;
            r_hit_count  <= '0;
            r_pending    <= 1'b0;
            r_spawn_side <= 1'b0;
            r_spawn      <= '0;
            r_active     <= '0;
            for (int i = 0; i < 2; i++) begin
                r_state[i] <= ST_FREE;
                r_cool[i]  <= '0;
            end
        end else begin
            r_lfsr      <= {r_lfsr[6:0], w_lfsr_fb};
            r_pending   <= (r_pending & ~w_spawn) | w_timer_done;
            r_spawn     <= w_sel;
            r_hit_count <= w_hit_sum[8] ? 8'hFF : w_hit_sum[7:0];

            if (w_tick) begin
                r_timer <= w_timer_done ? 8'd0 : r_timer + 8'd1;
            end

            if (w_spawn) begin
                r_spawn_side <= r_lfsr[7];
                r_spawn_y    <= {1'b0, r_lfsr[6:0]} + 8'd32;
            end

            for (int i = 0; i < 2; i++) begin
                case (r_state[i])
                    ST_FREE: begin
                        if (w_sel[i]) begin
                            r_state[i]  <= ST_ACTIVE;
                            r_active[i] <= 1'b1;
                        end
                    end
                    ST_ACTIVE: begin
                        if (w_leave[i]) begin
                            r_state[i]  <= ST_COOLDOWN;
                            r_cool[i]   <= LP_DELAY;
                            r_active[i] <= 1'b0;
                        end
                    end
                    ST_COOLDOWN: begin
                        // Release happens on the clock after the counter hits zero, tick or not.
                        if (r_cool[i] == 8'd0) begin
                            r_state[i] <= ST_FREE;
                        end else if (w_tick) begin
                            r_cool[i] <= r_cool[i] - 8'd1;
                        end
                    end
                    default: begin
                        r_state[i]  <= ST_FREE;
                        r_active[i] <= 1'b0;
                    end
                endcase
            end
        end
    end

    assign bus.bird1Spawn  = r_spawn[0];
    assign bus.bird2Spawn  = r_spawn[1];
    assign bus.bird1Active = r_active[0];
    assign bus.bird2Active = r_active[1];
    assign bus.spawnSide   = r_spawn_side;
    assign bus.spawnY      = r_spawn_y;
    assign bus.hitCount    = r_hit_count;

endmodule

// File: tb/tb_bird_slot_scheduler.sv
// tb/tb_bird_slot_scheduler.sv - directed bench for bird_slot_scheduler with SPAWN_PERIOD=3, RESPAWN_DELAY=2
module tb_bird_slot_scheduler;

    logic clk    = 1'b0;
    logic resetN = 1'b1;
    always #5 clk = ~clk;

    bird_slot_scheduler_if bus();

    bird_slot_scheduler #(
        .SPAWN_PERIOD (3),
        .RESPAWN_DELAY(2),
        .LFSR_SEED    (8'hA5)
    ) dut (
        .clk   (clk),
        .resetN(resetN),
        .bus   (bus)
    );

    int         total = 0;
    int         bad   = 0;
    logic [7:0] m_lfsr = 8'hA5;
    logic [7:0] exp_y;
    logic [7:0] exp_hits;
    logic       exp_side;

    // Reference LFSR: x^8+x^6+x^5+x^4+1, shifts every clock, seed on reset.
    always @(posedge clk) begin
        if (resetN) m_lfsr <= 8'hA5;
        else        m_lfsr <= {m_lfsr[6:0], m_lfsr[7] ^ m_lfsr[5] ^ m_lfsr[4] ^ m_lfsr[3]};
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic pulse();
        bus.startOfFrame = 1'b1;
        step();
        bus.startOfFrame = 1'b0;
    endtask

    task automatic capture();
        exp_side = m_lfsr[7];
        exp_y    = {1'b0, m_lfsr[6:0]} + 8'd32;
    endtask

    task automatic test_reset();
        bus.startOfFrame = 0; bus.enable = 0;
        bus.bird1Hit = 0; bus.bird2Hit = 0; bus.bird1Exited = 0; bus.bird2Exited = 0;
        resetN = 1'b1;
        step(); step(); step();
        total++; if ({bus.bird1Spawn, bus.bird2Spawn, bus.bird1Active, bus.bird2Active, bus.spawnSide} !== 5'b0) begin
            bad++; $display("FAIL reset_flags: got %b want 00000", {bus.bird1Spawn, bus.bird2Spawn, bus.bird1Active, bus.bird2Active, bus.spawnSide}); end
        total++; if ({bus.spawnY, bus.hitCount} !== 16'h0) begin
            bad++; $display("FAIL reset_y_hits: got %h want 0000", {bus.spawnY, bus.hitCount}); end
        resetN = 1'b0;
        step();
        total++; if ({bus.bird1Spawn, bus.bird2Spawn} !== 2'b00) begin
            bad++; $display("FAIL reset_release_spawn: got %b want 00", {bus.bird1Spawn, bus.bird2Spawn}); end
    endtask

    task automatic test_first_spawn();
        bus.enable = 1'b1;
        pulse(); step();
        pulse(); step();
        pulse();
        total++; if (bus.bird1Spawn !== 1'b0) begin
            bad++; $display("FAIL first_early: got %b want 0", bus.bird1Spawn); end
        capture();
        step();
        total++; if ({bus.bird1Spawn, bus.bird1Active, bus.bird2Spawn, bus.bird2Active} !== 4'b1100) begin
            bad++; $display("FAIL first_spawn: got %b want 1100", {bus.bird1Spawn, bus.bird1Active, bus.bird2Spawn, bus.bird2Active}); end
        total++; if ({bus.spawnSide, bus.spawnY} !== {exp_side, exp_y}) begin
            bad++; $display("FAIL first_pos: got %h want %h", {bus.spawnSide, bus.spawnY}, {exp_side, exp_y}); end
        step();
        total++; if (bus.bird1Spawn !== 1'b0) begin
            bad++; $display("FAIL first_one_cycle: got %b want 0", bus.bird1Spawn); end
    endtask

    task automatic test_second_and_pending();
        pulse(); step();
        pulse(); step();
        pulse();
        capture();
        step();
        total++; if ({bus.bird2Spawn, bus.bird2Active, bus.bird1Active, bus.bird1Spawn} !== 4'b1110) begin
            bad++; $display("FAIL second_spawn: got %b want 1110", {bus.bird2Spawn, bus.bird2Active, bus.bird1Active, bus.bird1Spawn}); end
        total++; if ({bus.spawnSide, bus.spawnY} !== {exp_side, exp_y}) begin
            bad++; $display("FAIL second_pos: got %h want %h", {bus.spawnSide, bus.spawnY}, {exp_side, exp_y}); end
        for (int k = 0; k < 3; k++) begin
            pulse(); step();
            total++; if ({bus.bird1Spawn, bus.bird2Spawn} !== 2'b00) begin
                bad++; $display("FAIL full_no_spawn: tick %0d got %b want 00", k, {bus.bird1Spawn, bus.bird2Spawn}); end
        end
        bus.bird1Hit = 1'b1;
        step();
        bus.bird1Hit = 1'b0;
        total++; if ({bus.bird1Active, bus.bird1Spawn, bus.hitCount} !== {2'b00, 8'd1}) begin
            bad++; $display("FAIL hit_to_cooldown: got %h want 001", {bus.bird1Active, bus.bird1Spawn, bus.hitCount}); end
        bus.startOfFrame = 1'b1;
        step(); step();
        bus.startOfFrame = 1'b0;
        total++; if (bus.bird1Spawn !== 1'b0) begin
            bad++; $display("FAIL cooldown_zero_spawn: got %b want 0", bus.bird1Spawn); end
        step();
        total++; if ({bus.bird1Spawn, bus.bird1Active} !== 2'b00) begin
            bad++; $display("FAIL freed_no_spawn_yet: got %b want 00", {bus.bird1Spawn, bus.bird1Active}); end
        capture();
        step();
        total++; if ({bus.bird1Spawn, bus.bird1Active, bus.spawnSide, bus.spawnY} !== {2'b11, exp_side, exp_y}) begin
            bad++; $display("FAIL respawn: got %h want %h", {bus.bird1Spawn, bus.bird1Active, bus.spawnSide, bus.spawnY}, {2'b11, exp_side, exp_y}); end
        step();
    endtask

    task automatic test_hits();
        bus.bird1Hit = 1'b1; bus.bird1Exited = 1'b1; bus.bird2Hit = 1'b1;
        step();
        bus.bird1Hit = 1'b0; bus.bird1Exited = 1'b0; bus.bird2Hit = 1'b0;
        total++; if ({bus.bird1Active, bus.bird2Active, bus.hitCount} !== {2'b00, 8'd3}) begin
            bad++; $display("FAIL double_hit: got %h want 003", {bus.bird1Active, bus.bird2Active, bus.hitCount}); end
        bus.bird1Hit = 1'b1; bus.bird2Exited = 1'b1;
        step();
        bus.bird1Hit = 1'b0; bus.bird2Exited = 1'b0;
        total++; if (bus.hitCount !== 8'd3) begin
            bad++; $display("FAIL cooldown_hit_ignored: got %0d want 3", bus.hitCount); end
    endtask

    task automatic test_enable_freeze();
        pulse(); pulse();
        bus.enable = 1'b0;
        step();
        for (int k = 0; k < 10; k++) begin
            pulse(); step();
            total++; if ({bus.bird1Spawn, bus.bird2Spawn, bus.bird1Active, bus.bird2Active} !== 4'b0000) begin
                bad++; $display("FAIL frozen: pulse %0d got %b want 0000", k, {bus.bird1Spawn, bus.bird2Spawn, bus.bird1Active, bus.bird2Active}); end
        end
        bus.enable = 1'b1;
        capture();
        step();
        total++; if ({bus.bird1Spawn, bus.bird2Spawn, bus.spawnSide, bus.spawnY} !== {2'b10, exp_side, exp_y}) begin
            bad++; $display("FAIL enable_spawn: got %h want %h", {bus.bird1Spawn, bus.bird2Spawn, bus.spawnSide, bus.spawnY}, {2'b10, exp_side, exp_y}); end
        step();
        pulse(); step();
        total++; if (bus.bird2Spawn !== 1'b0) begin
            bad++; $display("FAIL timer_frozen: got %b want 0", bus.bird2Spawn); end
        pulse();
        capture();
        step();
        total++; if ({bus.bird2Spawn, bus.bird2Active} !== 2'b11) begin
            bad++; $display("FAIL timer_resume: got %b want 11", {bus.bird2Spawn, bus.bird2Active}); end
        step();
    endtask

    task automatic test_saturation();
        int n;
        exp_hits = 8'd3;
        for (int r = 0; r < 130; r++) begin
            n = 0;
            while (!(bus.bird1Active && bus.bird2Active) && n < 40) begin
                pulse(); step(); step();
                n++;
            end
            if (n >= 40) begin
                total++; bad++;
                $display("FAIL sat_wait: round %0d got inactive slots want both active", r);
                break;
            end
            bus.bird1Hit = 1'b1; bus.bird2Hit = 1'b1;
            step();
            bus.bird1Hit = 1'b0; bus.bird2Hit = 1'b0;
            exp_hits = (exp_hits > 8'd253) ? 8'd255 : exp_hits + 8'd2;
            if (r == 124 || r == 129) begin
                total++; if (bus.hitCount !== exp_hits) begin
                    bad++; $display("FAIL hit_saturate: round %0d got %0d want %0d", r, bus.hitCount, exp_hits); end
            end
        end
    endtask

    task automatic test_reset_mid();
        pulse();
        resetN = 1'b1;
        bus.startOfFrame = 1'b1; bus.bird1Hit = 1'b1;
        step();
        bus.startOfFrame = 1'b0; bus.bird1Hit = 1'b0;
        total++; if ({bus.bird1Spawn, bus.bird2Spawn, bus.bird1Active, bus.bird2Active, bus.spawnSide, bus.spawnY, bus.hitCount} !== 21'h0) begin
            bad++; $display("FAIL mid_reset_outputs: got %h want 0", {bus.bird1Spawn, bus.bird2Spawn, bus.bird1Active, bus.bird2Active, bus.spawnSide, bus.spawnY, bus.hitCount}); end
        total++; if (dut.r_lfsr !== 8'hA5) begin
            bad++; $display("FAIL mid_reset_lfsr: got %h want a5", dut.r_lfsr); end
        step();
        resetN = 1'b0;
        step();
        total++; if ({bus.bird1Spawn, bus.bird2Spawn} !== 2'b00) begin
            bad++; $display("FAIL post_reset_spawn: got %b want 00", {bus.bird1Spawn, bus.bird2Spawn}); end
    endtask

    task automatic test_after_reset();
        bus.bird2Hit = 1'b1;
        step();
        bus.bird2Hit = 1'b0;
        total++; if ({bus.bird2Active, bus.hitCount} !== 9'd0) begin
            bad++; $display("FAIL free_hit_ignored: got %h want 000", {bus.bird2Active, bus.hitCount}); end
        pulse(); step();
        pulse(); step();
        pulse();
        capture();
        step();
        total++; if ({bus.bird1Spawn, bus.spawnSide, bus.spawnY} !== {1'b1, exp_side, exp_y}) begin
            bad++; $display("FAIL lfsr_spawn: got %h want %h", {bus.bird1Spawn, bus.spawnSide, bus.spawnY}, {1'b1, exp_side, exp_y}); end
        step(); step(); step();
        total++; if ({bus.bird1Spawn, bus.spawnSide, bus.spawnY} !== {1'b0, exp_side, exp_y}) begin
            bad++; $display("FAIL lfsr_hold: got %h want %h", {bus.bird1Spawn, bus.spawnSide, bus.spawnY}, {1'b0, exp_side, exp_y}); end
        pulse(); step();
        pulse(); step();
        pulse();
        bus.bird1Hit = 1'b1;
        capture();
        step();
        bus.bird1Hit = 1'b0;
        total++; if ({bus.bird2Spawn, bus.bird2Active, bus.bird1Active, bus.hitCount} !== {3'b110, 8'd1}) begin
            bad++; $display("FAIL spawn_and_hit: got %h want 601", {bus.bird2Spawn, bus.bird2Active, bus.bird1Active, bus.hitCount}); end
        total++; if ({bus.spawnSide, bus.spawnY} !== {exp_side, exp_y}) begin
            bad++; $display("FAIL spawn_and_hit_pos: got %h want %h", {bus.spawnSide, bus.spawnY}, {exp_side, exp_y}); end
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got timeout want test completion");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_first_spawn();
        test_second_and_pending();
        test_hits();
        test_enable_freeze();
        test_saturation();
        test_reset_mid();
        test_after_reset();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/bird_slot_scheduler.md
BIRD_SLOT_SCHEDULER -- requirements
Module: bird_slot_scheduler

Interface
REQ-001 SHALL have parameter SPAWN_PERIOD, default 120, frames between spawn requests (1..255).
REQ-002 SHALL have parameter RESPAWN_DELAY, default 60, frames a slot stays blocked after hit/exit (1..255).
REQ-003 SHALL have parameter LFSR_SEED, default 8'hA5, LFSR reset value (nonzero).
REQ-004 SHALL have port clk  in  1  system clock, all logic on rising edge.
REQ-005 SHALL have port resetN  in  1  reset; synchronous, active-high (1 = reset), despite the name suffix.
REQ-006 SHALL have port startOfFrame  in  1  one-cycle pulse per video frame.
REQ-007 SHALL have port enable  in  1  game running; 0 freezes all frame counters and spawning.
REQ-008 SHALL have ports bird1Hit, bird2Hit  in  1 each  one-cycle hit pulse per slot.
REQ-009 SHALL have ports bird1Exited, bird2Exited  in  1 each  one-cycle pulse, bird left screen.
REQ-010 SHALL have ports bird1Spawn, bird2Spawn  out  1 each  one-cycle spawn pulse to the bird sprite.
REQ-011 SHALL have ports bird1Active, bird2Active  out  1 each  slot in ACTIVE state.
REQ-012 SHALL have port spawnSide  out  1  0 = enter from left, 1 = from right.
REQ-013 SHALL have port spawnY  out  8  spawn height.
REQ-014 SHALL have port hitCount  out  8  saturating count of hits on active birds.

Function
REQ-015 Each slot SHALL run FSM FREE -> ACTIVE -> COOLDOWN -> FREE.
REQ-016 Frame tick SHALL be startOfFrame && enable; all frame counters advance only on ticks.
REQ-017 Spawn timer SHALL count ticks; on the tick reaching SPAWN_PERIOD it SHALL set pending and clear to 0.
REQ-018 While pending and a slot is FREE, the next clock SHALL spawn: lowest-index FREE slot (bird1 first), its Spawn pulsed exactly one cycle, slot -> ACTIVE, pending cleared.
REQ-019 At most one spawn SHALL occur per cycle and per pending request; pending SHALL NOT accumulate beyond 1.
REQ-020 If no slot is FREE, pending SHALL hold until one becomes FREE; the timer keeps counting.
REQ-021 enable=0 SHALL block spawns (pending held), freeze timer and cooldown counters; ACTIVE slots stay ACTIVE.
REQ-022 Hit or Exited on an ACTIVE slot SHALL move it to COOLDOWN next cycle, loading a counter with RESPAWN_DELAY.
REQ-023 Hit/Exited on a FREE or COOLDOWN slot SHALL be ignored.
REQ-024 Hit and Exited same cycle on one slot SHALL count as one hit.
REQ-025 COOLDOWN counter SHALL decrement per tick; on reaching 0 the slot SHALL become FREE next cycle.
REQ-026 hitCount SHALL add 1 per accepted hit; both slots hit same cycle adds 2; saturates at 255.
REQ-027 An 8-bit Fibonacci LFSR (taps x^8+x^6+x^5+x^4+1) SHALL advance every clock regardless of enable.
REQ-028 On each spawn, spawnSide SHALL load lfsr[7] and spawnY SHALL load {1'b0,lfsr[6:0]}+32, both held until the next spawn.
REQ-029 Spawn on a FREE slot and hit on the other slot in the same cycle SHALL both take effect.
REQ-030 All outputs SHALL be registered.

Reset
REQ-031 While resetN=1: both slots FREE, pending=0, timer=0, cooldown counters=0, LFSR=LFSR_SEED.
REQ-032 Reset outputs: Spawn=0, Active=0, spawnSide=0, spawnY=0, hitCount=0.
REQ-033 Reset asserted mid-operation SHALL override all other inputs that cycle; no spawn pulse is emitted during or on the cycle after reset.

Verification (SPAWN_PERIOD=3, RESPAWN_DELAY=2 unless noted)
REQ-034 Reset, enable=1, 3 startOfFrame pulses -> bird1Spawn high one cycle after the 3rd pulse, bird1Active=1, bird2 untouched.
REQ-035 6 more ticks, no hits -> bird2Spawn after the 6th tick; after 9 ticks no spawn, pending=1 and held; hit bird1 then 2 ticks -> bird1Spawn one cycle after bird1 becomes FREE.
REQ-036 bird1Hit and bird1Exited same cycle, bird2Hit same cycle -> hitCount +2 total, both COOLDOWN; hit on a COOLDOWN slot -> hitCount unchanged.
REQ-037 enable=0 for 10 startOfFrame pulses with pending=1 and a slot FREE -> no spawn, counters frozen; enable=1 -> spawn next cycle.
REQ-038 Force 260 accepted hits -> hitCount stops at 255; resetN=1 mid-cooldown -> all outputs 0 next cycle, LFSR=8'hA5.
REQ-039 Spawn after reset with LFSR_SEED=8'hA5 -> spawnSide and spawnY match LFSR reference model state at the spawn cycle; values stable until next spawn.
